// File: rtl/async_fifo_pkg.sv
// Shared types and pointer-code helpers for the asynchronous FIFO.
// Helpers work on zero-extended 32-bit values, so any pointer width up to 32 bits fits.
package async_fifo_pkg;

    localparam int PTR_MAX_W = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rd_state_e;

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a Gray-coded bus entering the clk domain.
module sync_ff #(
    parameter int WIDTH  = 5,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < STAGES; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: write-pointer sync, empty flag, FWFT output register.
// Define ASYNC_FIFO_RD_LEVEL_EN to build the rd_level / almost_empty logic.
module async_fifo_rd_ctrl
    import async_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH    = 4,
    parameter int DATA_WIDTH    = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  rd_clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
    input  logic [ADDR_WIDTH:0]   rd_ptr_bin,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  rd_en,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  fifo_empty,
    output logic [ADDR_WIDTH:0]   rd_level,
    output logic                  almost_empty
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    if (SYNC_STAGES < 2 || AEMPTY_THRESH < 0) begin : g_bad_param
        $error("async_fifo_rd_ctrl: SYNC_STAGES must be >= 2 and AEMPTY_THRESH >= 0");
    end

    logic [PTR_W-1:0]      wr_ptr_sync;
    rd_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    sync_ff #(
        .WIDTH (PTR_W),
        .STAGES(SYNC_STAGES)
    ) u_wr_ptr_sync (
        .clk  (rd_clk),
        .rst_n(rst_n),
        .d    (wr_ptr_gray),
        .q    (wr_ptr_sync)
    );

    assign fifo_empty = (ptr_word_t'(wr_ptr_sync) == bin2gray(ptr_word_t'(rd_ptr_bin)));

    // Gated by rst_n so a reset mid-transfer never pops the word it discards.
    assign rd_en = rst_n && !fifo_empty && (state_q == IDLE || dout_ready);

    // NOTE: defaults first so no path through the case leaves a value unassigned (no latch).
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (rd_en) begin
                    dout_d  = mem_rd_data;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (rd_en) begin
                    dout_d = mem_rd_data;
                end else if (dout_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = (state_q == HOLD);

`ifdef ASYNC_FIFO_RD_LEVEL_EN
    localparam logic [PTR_W-1:0] AEMPTY_LVL = PTR_W'(AEMPTY_THRESH);

    // Modulo-2^PTR_W subtraction absorbs pointer wrap; a stale sync pointer only under-reports.
    assign rd_level     = PTR_W'(gray2bin(ptr_word_t'(wr_ptr_sync)) - ptr_word_t'(rd_ptr_bin));
    assign almost_empty = (rd_level <= AEMPTY_LVL);
`else
    assign rd_level     = '0;
    assign almost_empty = 1'b0;
`endif

endmodule
